sobel_stream_pipe: RTL and testbench
====================================

// Module: sobel_stream_pipe
// PURPOSE
//  Streaming 3x3 Sobel edge engine. Accepts a raster-order grayscale pixel stream
//  with valid/ready, holds two line buffers plus a 3x3 window, and emits the
//  saturated L1 gradient magnitude |Gx|+|Gy| through a 2-stage pipeline.
//  Sits between the grayscale converter and the output/packer stage.
//  Parametrised in pixel width and line length; adds flow control and framing.
// PARAMETERS
//  PIXEL_W   8    bits per input/output pixel (unsigned)
//  IMG_W     64   pixels per line; line-buffer depth; must be >= 3
//  COL_W     $clog2(IMG_W)  column counter width (derived, localparam)
// PORTS
//  clk_i        in   1        single clock; all logic on rising edge
//  rst_i        in   1        synchronous, active-high reset
//  in_valid_i   in   1        input pixel valid
//  in_ready_o   out  1        block can accept a pixel this cycle
//  in_sof_i     in   1        qualifies in_pixel_i as row 0, col 0 of a new frame
//  in_pixel_i   in   PIXEL_W  grayscale pixel
//  out_valid_o  out  1        gradient result valid
//  out_ready_i  in   1        downstream accepts result
//  out_pixel_o  out  PIXEL_W  saturated magnitude (or binary edge, see CONFIG)
//  threshold_i  in   PIXEL_W  edge threshold (present only with SOBEL_THRESH_EN)
// BEHAVIOUR
//  - Reset: out_valid_o=0, out_pixel_o=0, col=0, row=0, pipe valids=0.
//    in_ready_o=1 after reset. Line-buffer RAM is not cleared.
//  - Advance: adv = !out_valid_o | out_ready_i; in_ready_o = adv. Accept = in_valid_i & adv.
//    When adv=0, all stages, counters, and buffers hold. out_pixel_o stays stable while
//    out_valid_o=1 & !out_ready_i.
//  - Counters (on accept): col 0..IMG_W-1, wraps to 0. Row increments on wrap and
//    saturates at 2. If in_sof_i=1, this pixel is treated as col=0,row=0 and the
//    counters restart from it, including mid-frame.
//  - Window: on accept, shift columns. New column = {linebuf1[col], linebuf0[col], pixel}.
//    Then linebuf1[col]<=linebuf0[col] and linebuf0[col]<=pixel.
//    p0..p8 in raster order: p0 top-left, p8 = current pixel.
//  - Window valid (stage-0 flag): accepted pixel has row>=2 && col>=2.
//    Each frame yields (IMG_W-2)*(H-2) outputs. No border padding.
//  - Stage 1 (registered): Gx=(p2-p0)+2(p5-p3)+(p8-p6), Gy=(p6-p0)+2(p7-p1)+(p8-p2).
//    Both are signed, PIXEL_W+3 bits.
//  - Stage 2 (registered): mag=|Gx|+|Gy| in PIXEL_W+3 bits unsigned.
//    If mag >= 2**PIXEL_W then out = 2**PIXEL_W-1, else out = mag[PIXEL_W-1:0].
//  - Latency: result of the window completed by pixel N is presented with out_valid_o=1
//    two advancing cycles after N is accepted. Throughput is 1 pixel/clk when
//    out_ready_i=1.
//  - Simultaneous accept and output handshake in one cycle is legal and lossless.
//  - Reset mid-frame: pending results are dropped. The next frame must start with in_sof_i.
// CONFIGURATION
//  SOBEL_THRESH_EN defined:
//    - Port threshold_i exists.
//    - Stage 2 outputs (sat_mag >= threshold_i) ? 2**PIXEL_W-1 : 0.
//    - threshold_i is sampled in the cycle stage 2 advances.
//  SOBEL_THRESH_EN undefined:
//    - No threshold_i port.
//    - Output is the saturated magnitude.
// TESTING (PIXEL_W=8, IMG_W=8, 4-line frames unless noted)
//  1 Flat frame, all pixels 100, out_ready_i=1:
//      exactly 12 outputs, all 0; none during rows 0-1 or cols 0-1.
//  2 Vertical step, cols 0-3 = 0 and cols 4-7 = 255:
//      outputs at cols 4 and 5 = 255 (saturated); all others = 0.
//  3 Vertical step 10 -> 20 at col 4:
//      Gx=40, Gy=0, so out=40 at cols 4 and 5; elsewhere 0.
//  4 Backpressure: hold out_ready_i=0 for 5 cycles while out_valid_o=1:
//      in_ready_o=0, out_pixel_o unchanged, no result lost or duplicated vs. golden model.
//  5 in_sof_i asserted at row 2 col 3 of a frame:
//      no outputs until 2 full lines plus 3 pixels after the sof pixel; counts match a new frame.
//  6 SOBEL_THRESH_EN, threshold_i=40, step of test 3:
//      out=255 at cols 4 and 5, else 0. With threshold_i=41, all outputs are 0.

Source files
------------

// File: rtl/sobel_stream_pipe.sv
// Streaming 3x3 Sobel edge engine: two line buffers, a 3x3 window and a 2-stage gradient pipeline.
// Optional binary-edge output enabled by defining SOBEL_THRESH_EN (adds port threshold_i).
module sobel_stream_pipe #(
    parameter int PIXEL_W = 8,
    parameter int IMG_W   = 64
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic               in_sof_i,
    input  logic [PIXEL_W-1:0] in_pixel_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [PIXEL_W-1:0] out_pixel_o
`ifdef SOBEL_THRESH_EN
    ,
    input  logic [PIXEL_W-1:0] threshold_i
`endif
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int GW    = PIXEL_W + 3;
    localparam logic [COL_W-1:0]   LAST_COL = COL_W'(IMG_W - 1);
    localparam logic [PIXEL_W-1:0] PIX_MAX  = '1;

    logic                      w_adv;
    logic                      w_accept;
    logic [COL_W-1:0]          w_col;
    logic [COL_W-1:0]          w_colNext;
    logic [1:0]                w_row;
    logic [1:0]                w_rowNext;
    logic signed [GW-1:0]      w_p [9];
    logic signed [GW-1:0]      w_gx;
    logic signed [GW-1:0]      w_gy;
    logic [GW-1:0]             w_absGx;
    logic [GW-1:0]             w_absGy;
    logic [GW-1:0]             w_mag;
    logic [PIXEL_W-1:0]        w_sat;
    logic [PIXEL_W-1:0]        w_stage2;

    logic [COL_W-1:0]          r_col;
    logic [1:0]                r_row;
    logic [PIXEL_W-1:0]        r_lineBuf0 [IMG_W];
    logic [PIXEL_W-1:0]        r_lineBuf1 [IMG_W];
    logic [PIXEL_W-1:0]        r_win [9];
    logic                      r_winValid;
    logic                      r_s1Valid;
    logic                      r_outValid;
    logic signed [GW-1:0]      r_gx;
    logic signed [GW-1:0]      r_gy;
    logic [PIXEL_W-1:0]        r_outPixel;

    // A start-of-frame pixel overrides the counters so the frame restarts from it.
    always_comb begin
        w_adv     = !r_outValid | out_ready_i;
        w_accept  = in_valid_i & w_adv;
        w_col     = in_sof_i ? '0 : r_col;
        w_row     = in_sof_i ? '0 : r_row;
        w_colNext = (w_col == LAST_COL) ? '0 : w_col + 1'b1;
        w_rowNext = ((w_col == LAST_COL) && (w_row != 2'd2)) ? w_row + 2'd1 : w_row;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            r_col <= w_colNext;
            r_row <= w_rowNext;
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            r_lineBuf1[w_col] <= r_lineBuf0[w_col];
            r_lineBuf0[w_col] <= in_pixel_i;
            r_win[0] <= r_win[1];
            r_win[1] <= r_win[2];
            r_win[2] <= r_lineBuf1[w_col];
            r_win[3] <= r_win[4];
            r_win[4] <= r_win[5];
            r_win[5] <= r_lineBuf0[w_col];
            r_win[6] <= r_win[7];
            r_win[7] <= r_win[8];
            r_win[8] <= in_pixel_i;
        end
    end

    always_comb begin
        for (int k = 0; k < 9; k++) begin
            w_p[k] = $signed({3'b000, r_win[k]});
        end
        w_gx = (w_p[2] - w_p[0]) + ((w_p[5] - w_p[3]) <<< 1) + (w_p[8] - w_p[6]);
        w_gy = (w_p[6] - w_p[0]) + ((w_p[7] - w_p[1]) <<< 1) + (w_p[8] - w_p[2]);
    end

    // Magnitude cannot exceed 2040 for 8-bit pixels, so PIXEL_W+3 bits never overflow.
    always_comb begin
        w_absGx = r_gx[GW-1] ? $unsigned(-r_gx) : $unsigned(r_gx);
        w_absGy = r_gy[GW-1] ? $unsigned(-r_gy) : $unsigned(r_gy);
        w_mag   = w_absGx + w_absGy;
        w_sat   = (|w_mag[GW-1:PIXEL_W]) ? PIX_MAX : w_mag[PIXEL_W-1:0];
`ifdef SOBEL_THRESH_EN
        w_stage2 = (w_sat >= threshold_i) ? PIX_MAX : '0;
`else
        w_stage2 = w_sat;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_winValid <= 1'b0;
            r_s1Valid  <= 1'b0;
            r_outValid <= 1'b0;
            r_gx       <= '0;
            r_gy       <= '0;
            r_outPixel <= '0;
        end else if (w_adv) begin
            r_winValid <= w_accept && (w_row == 2'd2) && (w_col >= COL_W'(2));
            r_s1Valid  <= r_winValid;
            r_outValid <= r_s1Valid;
            if (r_winValid) begin
                r_gx <= w_gx;
                r_gy <= w_gy;
            end
            if (r_s1Valid) begin
                r_outPixel <= w_stage2;
            end
        end
    end

    assign in_ready_o  = w_adv;
    assign out_valid_o = r_outValid;
    assign out_pixel_o = r_outPixel;

endmodule

// File: tb/tb_sobel_stream_pipe.sv
// Self-checking bench for sobel_stream_pipe (PIXEL_W=8, IMG_W=8, 4-line frames).
// Builds with or without SOBEL_THRESH_EN; a frame-level reference model predicts every result.
module tb_sobel_stream_pipe;

    localparam int IW = 8;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       in_valid_i;
    logic       in_ready_o;
    logic       in_sof_i;
    logic [7:0] in_pixel_i;
    logic       out_valid_o;
    logic       out_ready_i;
    logic [7:0] out_pixel_o;
`ifdef SOBEL_THRESH_EN
    logic [7:0] threshold_i;
`endif

    int total = 0;
    int bad   = 0;
    int readyMode = 0;
    int thr = 0;
    int expQ[$];
    int capQ[$];
    int img[4][IW];
    int mr = 0;
    int mc = 0;

    typedef struct {
        int leftVal;
        int rightVal;
        int expEdge;
        int expCount;
    } vec_t;
    vec_t vecs[5];

    sobel_stream_pipe #(.PIXEL_W(8), .IMG_W(IW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .in_sof_i    (in_sof_i),
        .in_pixel_i  (in_pixel_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_pixel_o (out_pixel_o)
`ifdef SOBEL_THRESH_EN
        ,
        .threshold_i (threshold_i)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, wanted %0d", name, actual, expected);
        end
    endtask

    function automatic int threshOf(input int sat);
`ifdef SOBEL_THRESH_EN
        return (sat >= thr) ? 255 : 0;
`else
        return sat;
`endif
    endfunction

    function automatic int px(input int r, input int c);
        return img[r % 4][c];
    endfunction

    // Reference: Sobel on the stored image rows, using the frame's true row/col coordinates.
    function automatic int refPixel(input int r, input int c);
        int gx, gy, mag;
        gx = (px(r-2, c) - px(r-2, c-2)) + 2 * (px(r-1, c) - px(r-1, c-2)) + (px(r, c) - px(r, c-2));
        gy = (px(r, c-2) - px(r-2, c-2)) + 2 * (px(r, c-1) - px(r-2, c-1)) + (px(r, c) - px(r-2, c));
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        return threshOf(mag > 255 ? 255 : mag);
    endfunction

    function automatic void modelAccept(input int pix, input bit sof);
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr % 4][mc] = pix;
        if (mr >= 2 && mc >= 2) expQ.push_back(refPixel(mr, mc));
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr++;
        end
    endfunction

    // Observe both handshakes on the falling edge, where all signals are settled.
    initial begin
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                if (in_valid_i && in_ready_o) modelAccept(int'(in_pixel_i), in_sof_i);
                if (out_valid_o && out_ready_i) begin
                    capQ.push_back(int'(out_pixel_o));
                    if (expQ.size() == 0) checkOutput("unexpectedOut", int'(out_pixel_o), -1);
                    else checkOutput("stream", int'(out_pixel_o), expQ.pop_front());
                end
            end
        end
    end

    initial begin
        out_ready_i = 1'b1;
        forever begin
            @(posedge clk_i);
            #1;
            case (readyMode)
                0:       out_ready_i = 1'b1;
                1:       out_ready_i = 1'($urandom_range(0, 1));
                default: out_ready_i = 1'b0;
            endcase
        end
    end

    task automatic sendPixel(input int pix, input bit sof);
        int waitCnt;
        waitCnt = 0;
        in_valid_i = 1'b1;
        in_pixel_i = 8'(pix);
        in_sof_i   = sof;
        @(negedge clk_i);
        while (!in_ready_o && waitCnt < 200) begin
            waitCnt++;
            @(negedge clk_i);
        end
        if (!in_ready_o) checkOutput("inReadyTimeout", int'(in_ready_o), 1);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        in_sof_i   = 1'b0;
    endtask

    // kind 0: step image (cols 0-3 = a, cols 4-7 = b); kind 1: random pixels.
    task automatic applyStimulus(input int kind, input int a, input int b, input int numPix,
                                 input int gap, input bit withSof);
        int pix;
        for (int i = 0; i < numPix; i++) begin
            repeat ($urandom_range(0, gap)) begin
                @(posedge clk_i);
                #1;
            end
            pix = (kind == 0) ? (((i % IW) < 4) ? a : b) : int'($urandom_range(0, 255));
            sendPixel(pix, withSof && (i == 0));
        end
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 300) begin
            @(negedge clk_i);
            n++;
        end
        if (expQ.size() != 0) checkOutput("drainTimeout", expQ.size(), 0);
        repeat (6) @(negedge clk_i);
    endtask

    initial begin
        int col, held, n;
        vecs[0] = '{100, 100,   0, 12};
        vecs[1] = '{  0, 255, 255, 12};
        vecs[2] = '{ 10,  20,  40, 12};
        vecs[3] = '{ 20,  10,  40, 12};
        vecs[4] = '{200,   0, 255, 12};

        rst_i      = 1'b1;
        in_valid_i = 1'b0;
        in_sof_i   = 1'b0;
        in_pixel_i = '0;
`ifdef SOBEL_THRESH_EN
        thr = 40;
        threshold_i = 8'd40;
`endif
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        @(negedge clk_i);
        checkOutput("rstOutValid", int'(out_valid_o), 0);
        checkOutput("rstOutPixel", int'(out_pixel_o), 0);
        checkOutput("rstInReady", int'(in_ready_o), 1);

        for (int v = 0; v < 5; v++) begin
            capQ.delete();
            applyStimulus(0, vecs[v].leftVal, vecs[v].rightVal, IW * 4, 0, 1'b1);
            waitDrain();
            checkOutput("tableCount", capQ.size(), vecs[v].expCount);
            for (int k = 0; k < capQ.size(); k++) begin
                col = 2 + k % (IW - 2);
                checkOutput("tableVal", capQ[k],
                            threshOf((col == 4 || col == 5) ? vecs[v].expEdge : 0));
            end
        end

        // Stall the output with a result pending; nothing may move.
        capQ.delete();
        applyStimulus(1, 0, 0, 2 * IW + 5, 0, 1'b1);
        readyMode = 2;
        n = 0;
        @(negedge clk_i);
        while (!(out_valid_o && !out_ready_i) && n < 20) begin
            @(negedge clk_i);
            n++;
        end
        checkOutput("stallReached", int'(out_valid_o && !out_ready_i), 1);
        held = int'(out_pixel_o);
        repeat (5) begin
            @(negedge clk_i);
            checkOutput("stallInReady", int'(in_ready_o), 0);
            checkOutput("stallValid", int'(out_valid_o), 1);
            checkOutput("stallHold", int'(out_pixel_o), held);
        end
        readyMode = 0;
        applyStimulus(1, 0, 0, IW * 4 - (2 * IW + 5), 0, 1'b0);
        waitDrain();
        checkOutput("stallCount", capQ.size(), 12);

        // Restart a frame at row 2 col 3 of the current one.
        capQ.delete();
        applyStimulus(1, 0, 0, 2 * IW + 3, 0, 1'b1);
        applyStimulus(1, 0, 0, IW * 4, 0, 1'b1);
        waitDrain();
        checkOutput("midSofCount", capQ.size(), 13);

        readyMode = 1;
        for (int f = 0; f < 6; f++) begin
            capQ.delete();
            applyStimulus(1, 0, 0, IW * 4, 3, 1'b1);
            waitDrain();
            checkOutput("randCount", capQ.size(), 12);
        end
        readyMode = 0;

        // Reset mid-frame drops pending results.
        applyStimulus(1, 0, 0, 2 * IW + 5, 0, 1'b1);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        expQ.delete();
        @(negedge clk_i);
        checkOutput("midRstValid", int'(out_valid_o), 0);
        capQ.delete();
        applyStimulus(0, 10, 20, IW * 4, 0, 1'b1);
        waitDrain();
        checkOutput("postRstCount", capQ.size(), 12);

`ifdef SOBEL_THRESH_EN
        thr = 41;
        threshold_i = 8'd41;
        capQ.delete();
        applyStimulus(0, 10, 20, IW * 4, 0, 1'b1);
        waitDrain();
        checkOutput("thr41Count", capQ.size(), 12);
        for (int k = 0; k < capQ.size(); k++) checkOutput("thr41Val", capQ[k], 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
